// File: rtl/w_value_ram_banked.sv
// w_value_ram_banked
//   Multi-bank weight-value RAM for the Newton-method divider datapath.
//   NUM_BANKS lanes of DATA_WIDTH-bit words share one address space. Each
//   lane has its own write enable. All lanes are read together through a
//   single registered read port. A clear sequencer sweeps every address to
//   zero after reset or on request. When enable is low, every piece of
//   state holds.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   enable      global stall (0 = hold everything)
//   clear       single-cycle request to zero the whole array
//   busy        high while the clear sweep runs
//   we          per-bank write enable
//   write_addr  shared write address
//   data        write data, bank b at data[b*DATA_WIDTH +: DATA_WIDTH]
//   read_en     read request
//   read_addr   read address
//   q           registered read data, same lane packing as data
//   q_valid     q was loaded by a read on the previous enabled edge
//
// state  | meaning
// IDLE   | user reads/writes accepted
// CLEAR  | zero sweep running at clr_addr, user inputs ignored

module w_value_ram_banked #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_BANKS  = 4,
    parameter int RDW_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            clear,
    output logic                            busy,
    input  logic [NUM_BANKS-1:0]            we,
    input  logic [ADDR_WIDTH-1:0]           write_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] data,
    input  logic                            read_en,
    input  logic [ADDR_WIDTH-1:0]           read_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] q,
    output logic                            q_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int QW    = NUM_BANKS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [QW-1:0]           q_q, q_d;
    logic                    q_valid_q, q_valid_d;
    logic [QW-1:0]           rd_data;

    logic [DATA_WIDTH-1:0]   mem [NUM_BANKS][DEPTH];

    // Per-lane read mux; the bypass only exists when RDW_MODE selects
    // new-data semantics, otherwise the array's pre-edge contents win.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (RDW_MODE == 1 && we[b] && (read_addr == write_addr))
                rd_data[b*DATA_WIDTH +: DATA_WIDTH] = data[b*DATA_WIDTH +: DATA_WIDTH];
            else
                rd_data[b*DATA_WIDTH +: DATA_WIDTH] = mem[b][read_addr];
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        if (enable) begin
            if (clear) begin
                // Restart (or start) the sweep; same-cycle user access is dropped.
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
                q_valid_d  = 1'b0;
            end else if (state_q == ST_CLEAR) begin
                clr_addr_d = clr_addr_q + 1'b1;
                q_valid_d  = 1'b0;
                if (clr_addr_q == CLR_LAST)
                    state_d = ST_IDLE;
            end else begin
                q_valid_d = read_en;
                if (read_en)
                    q_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    // Array has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (state_q == ST_CLEAR) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    mem[b][clr_addr_q] <= '0;
            end else if (!clear) begin
                for (int b = 0; b < NUM_BANKS; b++)
                    if (we[b])
                        mem[b][write_addr] <= data[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_w_value_ram_banked.sv
module tb_w_value_ram_banked;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int NB    = 4;
    localparam int DEPTH = 128;
    localparam int QW    = NB * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic [NB-1:0] we;
    logic [AW-1:0] write_addr;
    logic [QW-1:0] din;
    logic          read_en;
    logic [AW-1:0] read_addr;

    logic          busy0, busy1, qv0, qv1;
    logic [QW-1:0] q0, q1;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    always #5 clk = ~clk;

    w_value_ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RDW_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .busy(busy0),
        .we(we), .write_addr(write_addr), .data(din), .read_en(read_en),
        .read_addr(read_addr), .q(q0), .q_valid(qv0)
    );

    w_value_ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .RDW_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .busy(busy1),
        .we(we), .write_addr(write_addr), .data(din), .read_en(read_en),
        .read_addr(read_addr), .q(q1), .q_valid(qv1)
    );

    task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Memory is modelled as zeroed the moment a sweep starts: it cannot be
    // observed until the sweep finishes, so only the sweep length matters.
    logic [DW-1:0] mem_m [NB][DEPTH];
    logic [QW-1:0] q0_m, q1_m;
    logic          qv_m;
    int            sweep_left;
    logic          busy_m;

    assign busy_m = (sweep_left != 0);

    function automatic logic [QW-1:0] read_old(input logic [AW-1:0] a);
        logic [QW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*DW +: DW] = mem_m[b][a];
        return r;
    endfunction

    function automatic logic [QW-1:0] read_new(input logic [AW-1:0] a);
        logic [QW-1:0] r;
        r = read_old(a);
        for (int b = 0; b < NB; b++)
            if (we[b] && a == write_addr) r[b*DW +: DW] = din[b*DW +: DW];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_left <= DEPTH;
            q0_m <= '0;
            q1_m <= '0;
            qv_m <= 1'b0;
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++) mem_m[b][a] <= '0;
        end else if (enable) begin
            if (clear) begin
                sweep_left <= DEPTH;
                qv_m <= 1'b0;
                for (int b = 0; b < NB; b++)
                    for (int a = 0; a < DEPTH; a++) mem_m[b][a] <= '0;
            end else if (sweep_left > 0) begin
                sweep_left <= sweep_left - 1;
                qv_m <= 1'b0;
            end else begin
                qv_m <= read_en;
                if (read_en) begin
                    q0_m <= read_old(read_addr);
                    q1_m <= read_new(read_addr);
                end
                for (int b = 0; b < NB; b++)
                    if (we[b]) mem_m[b][write_addr] <= din[b*DW +: DW];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run_chk) begin
            chk("busy0", QW'(busy0), QW'(busy_m));
            chk("busy1", QW'(busy1), QW'(busy_m));
            chk("q_valid0", QW'(qv0), QW'(qv_m));
            chk("q_valid1", QW'(qv1), QW'(qv_m));
            chk("q_rdw0", q0, q0_m);
            chk("q_rdw1", q1, q1_m);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        clear = 1'b0; we = '0; read_en = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (!busy0) break;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] w, input logic [QW-1:0] d);
        we = w; write_addr = a; din = d; read_en = 1'b0;
        tick();
        we = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        read_en = 1'b1; read_addr = a;
        tick();
        read_en = 1'b0;
    endtask

    int n;
    logic [AW-1:0] ra_list [3];

    initial begin
        reset_n = 1'b1; enable = 1'b1; clear = 1'b0; we = '0;
        write_addr = '0; din = '0; read_en = 1'b0; read_addr = '0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_q0", q0, '0);
        chk("rst_qv0", QW'(qv0), '0);
        chk("rst_busy0", QW'(busy0), QW'(1));
        chk("rst_busy1", QW'(busy1), QW'(1));
        run_chk = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b1;

        count_busy(n);
        chk("sweep_len_after_reset", QW'(n), QW'(128));

        ra_list[0] = 7'd0; ra_list[1] = 7'd64; ra_list[2] = 7'd127;
        for (int i = 0; i < 3; i++) begin
            rd(ra_list[i]);
            chk("post_sweep_q0", q0, '0);
            chk("post_sweep_qv0", QW'(qv0), QW'(1));
        end

        // Per-bank write masking.
        wr(7'd5, 4'b1111, 32'h44332211);
        wr(7'd5, 4'b0101, 32'hDDCCBBAA);
        rd(7'd5);
        chk("bank_mask_q0", q0, 32'h44CC22AA);
        chk("bank_mask_q1", q1, 32'h44CC22AA);
        chk("bank_mask_model", q0_m, 32'h44CC22AA);

        // Same-address read during write.
        wr(7'd9, 4'b1111, 32'h01010101);
        we = 4'b1111; write_addr = 7'd9; din = 32'hFFFFFFFF;
        read_en = 1'b1; read_addr = 7'd9;
        tick();
        quiet();
        chk("rdw_old_q0", q0, 32'h01010101);
        chk("rdw_new_q1", q1, 32'hFFFFFFFF);
        chk("rdw_model0", q0_m, 32'h01010101);
        chk("rdw_model1", q1_m, 32'hFFFFFFFF);
        rd(7'd9);
        chk("rdw_after_q0", q0, 32'hFFFFFFFF);

        // Stall: nothing may change while enable is low.
        wr(7'd3, 4'b1111, 32'hA5A53C3C);
        rd(7'd3);
        chk("stall_pre_q0", q0, 32'hA5A53C3C);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we = NB'($urandom); write_addr = 7'd3; din = $urandom;
            read_en = 1'b1; read_addr = AW'($urandom);
            clear = (i % 2 == 0);
            tick();
        end
        chk("stall_q0", q0, 32'hA5A53C3C);
        chk("stall_qv0", QW'(qv0), QW'(1));
        chk("stall_busy0", QW'(busy0), '0);
        enable = 1'b1;
        quiet();
        rd(7'd3);
        chk("stall_mem_q0", q0, 32'hA5A53C3C);

        // Clear restarted mid-sweep at address 60.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_busy_now", QW'(busy0), QW'(1));
        repeat (60) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        count_busy(n);
        chk("sweep_len_restart", QW'(n), QW'(128));

        // Asynchronous reset while holding valid read data.
        wr(7'd20, 4'b1111, 32'h12345678);
        rd(7'd20);
        chk("pre_rst_q0", q0, 32'h12345678);
        chk("pre_rst_qv0", QW'(qv0), QW'(1));
        reset_n = 1'b0;
        #1;
        chk("async_rst_q0", q0, '0);
        chk("async_rst_q1", q1, '0);
        chk("async_rst_qv0", QW'(qv0), '0);
        chk("async_rst_busy0", QW'(busy0), QW'(1));
        @(posedge clk);
        #2 reset_n = 1'b1;
        count_busy(n);
        chk("sweep_len_rst2", QW'(n), QW'(128));
        rd(7'd20);
        chk("cleared_addr20", q0, '0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 299) == 0);
            we         = NB'($urandom);
            write_addr = AW'($urandom_range(0, 15));
            din        = $urandom;
            read_en    = $urandom_range(0, 1) == 1;
            read_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            tick();
        end
        enable = 1'b1;
        quiet();
        count_busy(n);
        tick();
        run_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
